aux_uart_tx: RTL and testbench

Byte-oriented 8N1 UART transmitter with a small input FIFO, the transmit end of the auxiliary UART link whose receive side loads programs into the MCU. It sits in the board top level beside the MCU and drives a GPIO pin. Typical use is streaming debug bytes, such as memory-bus trace data or port writes, to a host. All logic runs in the `clk` domain; the output pin is registered and glitch-free.

---
 rtl/aux_uart_tx.sv | 140 ++++++++++++++
 tb/tb_aux_uart_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; the line idles high and
// consecutive queued bytes go out back-to-back with no idle gap.
module aux_uart_tx #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    o_dbg_state
);
  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("aux_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("aux_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on registered pointers, never on the current pop.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_bit_end = (r_baud == LAST_CNT);
  assign w_push    = in_valid && !w_full;
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  assign in_ready    = !w_full;
  assign fifo_count  = r_wr_ptr - r_rd_ptr;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign tx          = r_tx;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        default: begin
          r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
          if (w_bit_end) begin
            case (r_state)
              S_START: begin
                r_tx      <= r_shift[0];
                r_bit_idx <= 3'd0;
                r_state   <= S_DATA;
              end
              S_DATA: begin
                if (r_bit_idx == 3'd7) begin
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  // Next bit is driven from shift[1] so tx moves exactly on the boundary.
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_tx      <= r_shift[1];
                  r_bit_idx <= r_bit_idx + 3'd1;
                end
              end
              S_STOP: begin
                if (w_pop) begin
                  r_shift <= w_head;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
                end else begin
                  r_state <= S_IDLE;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aux_uart_tx.sv
// Bench for aux_uart_tx: a 10-clocks-per-bit instance for protocol checks and
// a default-parameter instance for 434-clock bit timing.
module tb_aux_uart_tx;
  logic       clk;
  logic       a_rstn, a_valid, a_ready, a_tx, a_busy;
  logic [7:0] a_data;
  logic [2:0] a_cnt;
  logic [1:0] a_dbg;
  logic       b_rstn, b_valid, b_ready, b_tx, b_busy;
  logic [7:0] b_data;
  logic [2:0] b_cnt;
  logic [1:0] b_dbg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  aux_uart_tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .resetb(a_rstn), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .tx(a_tx), .busy(a_busy), .fifo_count(a_cnt),
    .o_dbg_state(a_dbg)
  );

  aux_uart_tx dut_b (
    .clk(clk), .resetb(b_rstn), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .tx(b_tx), .busy(b_busy), .fifo_count(b_cnt),
    .o_dbg_state(b_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txs(input bit sel);
    return sel ? b_tx : a_tx;
  endfunction

  // driver: call at a negedge; returns at the negedge after the accepting edge
  task automatic push_a(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    a_valid = 1'b1;
    a_data  = b;
    while (a_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (a_ready !== 1'b1) begin
      chk("push_ready_timeout", 32'(a_ready), 32'd1);
      acc_cyc = -1;
    end else begin
      exp_q.push_back(b);
      acc_cyc = cyc + 1;
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = 8'($urandom_range(0, 255));
  endtask

  // scoreboard: finds the next start bit, then checks every cycle of the frame
  // against the ideal waveform of the oldest expected byte
  task automatic frame_chk(input bit sel, input int cpb, output int t_fall);
    logic [9:0] bits;
    logic [7:0] b;
    int n;
    n = 0;
    @(negedge clk);
    while (txs(sel) !== 1'b0 && n < 20 * cpb) begin
      @(negedge clk);
      n++;
    end
    t_fall = cyc;
    if (txs(sel) !== 1'b0) begin
      chk("frame_start_timeout", 32'(txs(sel)), 32'd0);
      return;
    end
    chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
    b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < 10 * cpb; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("frame_%02h_bit%0d", b, j / cpb), 32'(txs(sel)), 32'(bits[j / cpb]));
    end
  endtask

  initial begin
    int e0, x, acc4, acc5;
    int tf[6];
    int tf_prev, tf_r;

    a_rstn = 1'b1; b_rstn = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    #2;
    a_rstn = 1'b0; b_rstn = 1'b0;

    // reset values with random inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_valid = 1'($urandom_range(0, 1));
      a_data  = 8'($urandom_range(0, 255));
      b_valid = 1'($urandom_range(0, 1));
      b_data  = 8'($urandom_range(0, 255));
      chk("rst_tx", 32'(a_tx), 32'd1);
      chk("rst_ready", 32'(a_ready), 32'd1);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_count", 32'(a_cnt), 32'd0);
      chk("rst_b_tx", 32'(b_tx), 32'd1);
      chk("rst_b_count", 32'(b_cnt), 32'd0);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    a_rstn = 1'b1; b_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(a_tx), 32'd1);
      chk("idle_busy", 32'(a_busy), 32'd0);
    end

    // single byte A5
    push_a(8'hA5, e0);
    chk("single_count", 32'(a_cnt), 32'd1);
    chk("single_busy", 32'(a_busy), 32'd1);
    chk("single_tx_pre", 32'(a_tx), 32'd1);
    frame_chk(1'b0, 10, tf[0]);
    chk("single_fall_edge", 32'(tf[0]), 32'(e0 + 1));
    chk("single_busy_stop", 32'(a_busy), 32'd1);
    @(negedge clk);
    chk("single_busy_drop", 32'(a_busy), 32'd0);
    chk("single_tx_idle", 32'(a_tx), 32'd1);
    repeat (5) @(negedge clk);

    // backpressure: 6 bytes with in_valid held high
    acc4 = 0; acc5 = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push_a(8'(i), x);
          if (i == 4) begin
            acc4 = x;
            chk("bp_full_count", 32'(a_cnt), 32'd4);
            chk("bp_full_ready", 32'(a_ready), 32'd0);
          end
          if (i == 5) acc5 = x;
          if (i < 5) begin
            a_valid = 1'b1;
            a_data  = 8'(i + 1);
          end
        end
      end
      begin
        for (int i = 0; i < 6; i++) frame_chk(1'b0, 10, tf[i]);
      end
    join
    for (int i = 1; i < 6; i++) chk("bp_spacing", 32'(tf[i] - tf[i-1]), 32'd100);
    chk("bp_accept_after_pop", 32'(acc5), 32'(tf[1] + 1));
    chk("bp_acc4", 32'(acc4 - tf[0]), 32'd3);
    repeat (5) @(negedge clk);

    // push on the edge a frame ends with two bytes queued
    fork
      begin
        push_a(8'($urandom_range(0, 255)), e0);
        push_a(8'($urandom_range(0, 255)), x);
        push_a(8'($urandom_range(0, 255)), x);
        chk("sim_count_pre", 32'(a_cnt), 32'd2);
        while (cyc < e0 + 100) @(negedge clk);
        push_a(8'($urandom_range(0, 255)), x);
        chk("sim_accept_edge", 32'(x), 32'(e0 + 101));
        chk("sim_count_hold", 32'(a_cnt), 32'd2);
      end
      begin
        for (int i = 0; i < 4; i++) frame_chk(1'b0, 10, tf[i]);
      end
    join
    chk("sim_first_fall", 32'(tf[0]), 32'(e0 + 1));
    for (int i = 1; i < 4; i++) chk("sim_spacing", 32'(tf[i] - tf[i-1]), 32'd100);
    repeat (5) @(negedge clk);

    // reset during data bit 3 of FF with two bytes queued
    push_a(8'hFF, e0);
    push_a(8'($urandom_range(0, 255)), x);
    push_a(8'($urandom_range(0, 255)), x);
    chk("rmid_count_pre", 32'(a_cnt), 32'd2);
    while (cyc < e0 + 1 + 44) @(negedge clk);
    chk("rmid_bit3", 32'(a_tx), 32'd1);
    chk("rmid_busy_pre", 32'(a_busy), 32'd1);
    a_rstn = 1'b0;
    #1;
    chk("rmid_tx", 32'(a_tx), 32'd1);
    chk("rmid_count", 32'(a_cnt), 32'd0);
    chk("rmid_busy", 32'(a_busy), 32'd0);
    chk("rmid_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_rstn = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_a(8'h3C, e0);
    frame_chk(1'b0, 10, tf[0]);
    chk("rmid_3c_fall", 32'(tf[0]), 32'(e0 + 1));
    x = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1) x++;
    end
    chk("rmid_no_extra_frame", 32'(x), 32'd0);
    chk("rmid_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rmid_busy_end", 32'(a_busy), 32'd0);

    // random bytes with random producer gaps
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 15)) @(negedge clk);
          push_a(8'($urandom_range(0, 255)), x);
        end
      end
      begin
        tf_prev = 0;
        for (int i = 0; i < 10; i++) begin
          frame_chk(1'b0, 10, tf_r);
          if (i > 0) chk("rand_spacing", 32'(tf_r - tf_prev >= 100), 32'd1);
          tf_prev = tf_r;
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("rand_busy_end", 32'(a_busy), 32'd0);
    chk("rand_count_end", 32'(a_cnt), 32'd0);
    chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    // default parameters: 434 clocks per bit
    @(negedge clk);
    chk("dflt_ready", 32'(b_ready), 32'd1);
    b_valid = 1'b1;
    b_data  = 8'h55;
    exp_q.push_back(8'h55);
    e0 = cyc + 1;
    @(negedge clk);
    b_valid = 1'b0;
    chk("dflt_count", 32'(b_cnt), 32'd1);
    frame_chk(1'b1, 434, tf[0]);
    chk("dflt_fall_edge", 32'(tf[0]), 32'(e0 + 1));
    chk("dflt_busy_stop", 32'(b_busy), 32'd1);
    @(negedge clk);
    chk("dflt_busy_drop", 32'(b_busy), 32'd0);
    chk("dflt_tx_idle", 32'(b_tx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
